// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tick_scheduler
// Summary  : One base prescaler drives NUM_CH programmable slow-tick channels.
//            Optional macro TICK_ONESHOT_EN adds one-shot channel mode.
// Revision : 1.0
// ============================================================================
module tick_scheduler #(
  parameter int BASE_DIV = 3_333_334,
  parameter int NUM_CH   = 4,
  parameter int PER_W    = 8,
  parameter int CH_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PER_W-1:0]  cfg_period,
`ifdef TICK_ONESHOT_EN
  input  logic              cfg_oneshot,
`endif
  output logic              base_tick,
  output logic [NUM_CH-1:0] ch_tick,
  output logic [NUM_CH-1:0] ch_active
);

  localparam int               CNT_W  = $clog2(BASE_DIV);
  localparam logic [CNT_W-1:0] C_WRAP = CNT_W'(BASE_DIV - 1);

  logic [CNT_W-1:0] r_pre_cnt;
  logic             r_base_tick;

  // Prescaler: counter freezes while enable is low, so no pulse is lost or added.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt   <= '0;
      r_base_tick <= 1'b0;
    end else begin
      r_base_tick <= 1'b0;
      if (enable) begin
        if (r_pre_cnt == C_WRAP) begin
          r_pre_cnt   <= '0;
          r_base_tick <= 1'b1;
        end else begin
          r_pre_cnt <= r_pre_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign base_tick = r_base_tick;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [PER_W-1:0] r_period;
      logic [PER_W-1:0] r_cnt;
      logic             r_tick;
      logic             r_active;
      logic             w_wr_sel;
      logic             w_last;

      // Out-of-range indices never match any channel, so such writes are dropped.
      assign w_wr_sel = cfg_we && (cfg_ch == CH_W'(k));
      assign w_last   = (r_cnt == (r_period - PER_W'(1)));

`ifdef TICK_ONESHOT_EN
      logic r_oneshot;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_oneshot <= 1'b0;
        end else if (w_wr_sel) begin
          r_oneshot <= cfg_oneshot;
        end
      end
`endif

      // A write in the same cycle as base_tick wins; that base tick is not counted.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_period <= '0;
          r_cnt    <= '0;
          r_tick   <= 1'b0;
          r_active <= 1'b0;
        end else begin
          r_tick   <= 1'b0;
          r_active <= (r_period != '0);
          if (w_wr_sel) begin
            r_period <= cfg_period;
            r_cnt    <= '0;
          end else if (r_base_tick && (r_period != '0)) begin
            if (w_last) begin
              r_cnt  <= '0;
              r_tick <= 1'b1;
`ifdef TICK_ONESHOT_EN
              if (r_oneshot) begin
                r_period <= '0;
              end
`endif
            end else begin
              r_cnt <= r_cnt + PER_W'(1);
            end
          end
        end
      end

      assign ch_tick[k]   = r_tick;
      assign ch_active[k] = r_active;
    end
  endgenerate

endmodule
`default_nettype wire
